pagerank_dmp_reducer: RTL

Parametrised successor to the DMP serialisation stage of the partitioned PageRank pipeline. Waits until every participating hardware thread has finished its gather phase, then reduces the per-thread pre-damping vectors node by node and streams the sums to the PageRank compute stage, LANES nodes per beat, under valid/ready backpressure. It adds a thread participation mask, multi-lane output, abort on iteration change and overflow detection.

---
 rtl/pagerank_dmp_reducer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pagerank_dmp_reducer.sv
// Reduces masked per-thread PageRank gather vectors node by node and streams LANES sums per beat.
// Latency: first beat valid one cycle after all participating threads are done; then 1 beat/cycle.
// Backpressure: out_valid/out_ready; beat held stable while stalled. Optional macro: PR_SAT_ADD_EN.
module pagerank_dmp_reducer #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 64,
  parameter int LANES          = 4,
  parameter int DATA_W         = 64
) (
  input  logic                                                      clock,
  input  logic                                                      reset_n,
  input  logic                                                      start,
  input  logic [NUM_HW_THREADS-1:0]                                 thread_mask,
  input  logic [NUM_HW_THREADS-1:0]                                 thread_done,
  input  logic [NUM_HW_THREADS-1:0][NODES_IN_GRAPH-1:0][DATA_W-1:0] page_rank_gather,
  input  logic                                                      next_iteration,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic [LANES-1:0][DATA_W-1:0]                              out_data,
  output logic [31:0]                                               out_base_index,
  output logic                                                      stream_start,
  output logic                                                      stream_done,
  output logic                                                      busy,
  output logic                                                      overflow
);

  // Wide enough that summing every thread can never wrap before overflow is judged.
  localparam int          SUM_W     = DATA_W + $clog2(NUM_HW_THREADS) + 1;
  localparam int          IDX_W     = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [31:0] LAST_BASE = 32'(NODES_IN_GRAPH - LANES);
  localparam logic [31:0] LANES_32  = 32'(LANES);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, STREAM} state_t;

  state_t                          state, state_nxt;
  logic [NUM_HW_THREADS-1:0]       mask_q;
  logic [NUM_HW_THREADS-1:0]       done_seen;
  logic                            all_done;
  logic                            accept;
  logic                            last_beat;
  logic                            accept_start;
  logic                            load_beat;
  logic                            finish;
  logic [31:0]                     load_base;
  logic [IDX_W-1:0]                node_idx;
  logic [LANES-1:0][SUM_W-1:0]     acc;
  logic [LANES-1:0][DATA_W-1:0]    lane_sum;
  logic [LANES-1:0]                lane_ovf;

  // A thread counts as done if seen earlier, done this cycle, or not participating.
  assign all_done  = &(done_seen | thread_done | ~mask_q);
  assign accept    = out_valid & out_ready;
  assign last_beat = (out_base_index == LAST_BASE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an iteration change overrides everything else.
  always_comb begin
    state_nxt = state;
    if (next_iteration) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (start) state_nxt = WAIT_DONE;
        WAIT_DONE: if (all_done) state_nxt = STREAM;
        STREAM:    if (accept && last_beat) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Control strobes and the base of the beat to be loaded at the coming edge.
  always_comb begin
    accept_start = 1'b0;
    load_beat    = 1'b0;
    finish       = 1'b0;
    load_base    = out_base_index + LANES_32;
    if (!next_iteration) begin
      case (state)
        IDLE:      accept_start = start;
        WAIT_DONE: begin
          load_beat = all_done;
          load_base = '0;
        end
        STREAM: begin
          if (accept) begin
            if (last_beat) finish = 1'b1;
            else           load_beat = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-lane reduction over the participating threads for the beat at load_base.
  always_comb begin
    acc      = '0;
    lane_sum = '0;
    lane_ovf = '0;
    node_idx = '0;
    for (int j = 0; j < LANES; j++) begin
      node_idx = load_base[IDX_W-1:0] + IDX_W'(j);
      for (int i = 0; i < NUM_HW_THREADS; i++) begin
        if (mask_q[i]) acc[j] = acc[j] + SUM_W'(page_rank_gather[i][node_idx]);
      end
      lane_ovf[j] = |acc[j][SUM_W-1:DATA_W];
`ifdef PR_SAT_ADD_EN
      lane_sum[j] = lane_ovf[j] ? {DATA_W{1'b1}} : acc[j][DATA_W-1:0];
`else
      lane_sum[j] = acc[j][DATA_W-1:0];
`endif
    end
  end

  // Round bookkeeping and the output beat register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q         <= '0;
      done_seen      <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_base_index <= '0;
      stream_start   <= 1'b0;
      stream_done    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      stream_start <= 1'b0;
      stream_done  <= 1'b0;
      if (next_iteration) begin
        done_seen <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept_start) begin
          mask_q    <= thread_mask;
          done_seen <= '0;
          overflow  <= 1'b0;
        end
        if (state == WAIT_DONE) done_seen <= done_seen | (thread_done & mask_q);
        if (load_beat) begin
          out_data       <= lane_sum;
          out_base_index <= load_base;
          out_valid      <= 1'b1;
          stream_start   <= (state == WAIT_DONE);
          overflow       <= overflow | (|lane_ovf);
        end
        if (finish) begin
          out_valid   <= 1'b0;
          stream_done <= 1'b1;
        end
      end
    end
  end

endmodule
